// File: rtl/icache_plru_refill.sv
// rtl/icache_plru_refill.sv - set-associative I-cache with MRU-bit PLRU and block refill FSM
module icache_plru_refill #(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic              flush,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int OFF_W = $clog2(WORDS * 4);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MISS_REQ, S_REFILL, S_RESPOND, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   fidx_q, fidx_d;
  logic               flush_pend_q, flush_pend_d;

  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    mru_q   [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [31:0]        data_q  [SETS][WAYS][WORDS];

  logic [IDX_W-1:0]   req_idx, lat_idx;
  logic [TAG_W-1:0]   req_tag, lat_tag;
  logic [CNT_W-1:0]   req_word, lat_word;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim;
  logic               hit_upd, fill_done, beat_we, flush_clr;
  logic               unused_addr_bits;

  assign req_idx  = cpu_addr[OFF_W +: IDX_W];
  assign req_tag  = cpu_addr[OFF_W + IDX_W +: TAG_W];
  assign req_word = (WORDS == 1) ? '0 : cpu_addr[2 +: CNT_W];
  assign lat_idx  = addr_q[OFF_W +: IDX_W];
  assign lat_tag  = addr_q[OFF_W + IDX_W +: TAG_W];
  assign lat_word = (WORDS == 1) ? '0 : addr_q[2 +: CNT_W];
  assign busy     = (state_q != S_IDLE);
  assign unused_addr_bits = ^{cpu_addr[1:0], addr_q[1:0]};

  // Set the touched way's MRU bit; if the set would become all-MRU, keep only that way.
  function automatic logic [WAYS-1:0] plru_next(input logic [WAYS-1:0] m, input logic [WAY_W-1:0] way);
    logic [WAYS-1:0] one;
    logic [WAYS-1:0] n;
    one      = '0;
    one[way] = 1'b1;
    n        = m | one;
    return (&n) ? one : n;
  endfunction

  // Parallel tag compare across all ways of the requested set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise lowest way whose MRU bit is clear.
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[req_idx][w]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !mru_q[req_idx][w]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
  end

  // Next-state and output logic of the control FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    victim_d     = victim_q;
    cnt_d        = cnt_q;
    fidx_d       = fidx_q;
    flush_pend_d = flush_pend_q | flush;
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    hit_upd      = 1'b0;
    fill_done    = 1'b0;
    beat_we      = 1'b0;
    flush_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush || flush_pend_q) begin
          state_d      = S_FLUSH;
          fidx_d       = '0;
          flush_pend_d = 1'b0;
        end else if (cpu_req) begin
          if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data_q[req_idx][hit_way][req_word];
            hit_upd   = 1'b1;
          end else begin
            addr_d   = cpu_addr;
            victim_d = victim;
            state_d  = S_MISS_REQ;
          end
        end
      end
      S_MISS_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (mem_ack) begin
          state_d = S_REFILL;
          cnt_d   = '0;
        end
      end
      S_REFILL: begin
        if (mem_rvalid) begin
          beat_we = 1'b1;
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            cnt_d     = '0;
            fill_done = 1'b1;
            state_d   = S_RESPOND;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RESPOND: begin
        cpu_ready = 1'b1;
        cpu_rdata = data_q[lat_idx][victim_q][lat_word];
        state_d   = S_IDLE;
      end
      S_FLUSH: begin
        flush_clr = 1'b1;
        fidx_d    = fidx_q + 1'b1;
        if (fidx_q == IDX_W'(SETS - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      victim_q     <= '0;
      cnt_q        <= '0;
      fidx_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      victim_q     <= victim_d;
      cnt_q        <= cnt_d;
      fidx_q       <= fidx_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Valid and MRU bits: cleared by reset or flush sweep, updated on hit and refill completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        mru_q[s]   <= '0;
      end
    end else begin
      if (flush_clr) begin
        valid_q[fidx_q] <= '0;
        mru_q[fidx_q]   <= '0;
      end
      if (hit_upd) begin
        mru_q[req_idx] <= plru_next(mru_q[req_idx], hit_way);
      end
      if (fill_done) begin
        valid_q[lat_idx][victim_q] <= 1'b1;
        mru_q[lat_idx]             <= plru_next(mru_q[lat_idx], victim_q);
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (beat_we) begin
      data_q[lat_idx][victim_q][cnt_q] <= mem_rdata;
    end
    if (fill_done) begin
      tag_q[lat_idx][victim_q] <= lat_tag;
    end
  end

endmodule

// File: tb/tb_icache_plru_refill.sv
// tb/tb_icache_plru_refill.sv - self-checking bench for icache_plru_refill
module tb_icache_plru_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        flush;
  logic        busy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:16383];
  bit          m_valid [4][2];
  bit          m_mru   [4][2];
  logic [9:0]  m_tag   [4][2];
  logic [31:0] m_data  [4][2][4];

  always #5 clk = ~clk;

  icache_plru_refill #(.ADDR_W(16), .WAYS(2), .SETS(4), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .flush(flush), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  function automatic int m_lookup(input int s, input logic [9:0] t);
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic void m_touch(input int s, input int w);
    m_mru[s][w] = 1'b1;
    if (m_mru[s][0] && m_mru[s][1]) begin
      m_mru[s][0] = 1'b0;
      m_mru[s][1] = 1'b0;
      m_mru[s][w] = 1'b1;
    end
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < 2; w++) if (!m_valid[s][w]) return w;
    for (int w = 0; w < 2; w++) if (!m_mru[s][w]) return w;
    return 0;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 4; s++) for (int w = 0; w < 2; w++) begin
      m_valid[s][w] = 1'b0;
      m_mru[s][w]   = 1'b0;
    end
  endfunction

  // One complete fetch: hit or full miss/refill, with memory responder and reference model update.
  task automatic do_access(input logic [15:0] a, input int exp_hit, input int gap_pct, input int ack_dly,
                           input logic [15:0] pat, input int pat_len, input int flush_at, input int exp_lat);
    int s, wd, w, v, cyc, bt, n, bound;
    logic [9:0]  t;
    logic [15:0] blk;
    logic [31:0] exp;
    logic        eh;
    s   = int'(a[5:4]);
    wd  = int'(a[3:2]);
    t   = a[15:6];
    blk = {a[15:4], 4'h0};
    eh  = (exp_hit == 1);
    cpu_req  = 1'b1;
    cpu_addr = a;
    #1;
    w = m_lookup(s, t);
    if (exp_hit >= 0) begin
      checks++;
      if (cpu_ready !== eh) begin
        errors++;
        $display("FAIL hit_expect addr=%h: cpu_ready=%b required %b", a, cpu_ready, eh);
      end
    end
    if (w >= 0) begin
      exp = m_data[s][w][wd];
      checks++;
      if (cpu_ready !== 1'b1 || cpu_rdata !== exp) begin
        errors++;
        $display("FAIL hit addr=%h: ready=%b rdata=%h required ready=1 rdata=%h", a, cpu_ready, cpu_rdata, exp);
      end
      m_touch(s, w);
      @(negedge clk);
      cpu_req = 1'b0;
    end else begin
      checks++;
      if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL miss_first addr=%h: ready=%b mem_req=%b required 0 0", a, cpu_ready, mem_req);
      end
      v = m_victim(s);
      @(negedge clk);
      cyc   = 1;
      bound = 0;
      while (mem_req !== 1'b1 && bound < 20) begin
        @(negedge clk);
        cyc++;
        bound++;
      end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== blk) begin
        errors++;
        $display("FAIL mem_req addr=%h: mem_req=%b mem_addr=%h required 1 %h", a, mem_req, mem_addr, blk);
      end
      for (int i = 0; i < ack_dly; i++) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        @(negedge clk);
        cyc++;
      end
      mem_rvalid = 1'b0;
      mem_ack    = 1'b1;
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      bt = 0;
      n  = 0;
      while (bt < 4 && n < 200) begin
        if (n < pat_len) mem_rvalid = pat[n];
        else mem_rvalid = ($urandom_range(0, 99) >= gap_pct);
        flush = (n == flush_at);
        if (mem_rvalid) begin
          mem_rdata = mem[{blk[15:4], bt[1:0]}];
          bt++;
        end else begin
          mem_rdata = $urandom;
        end
        #1;
        checks++;
        if (cpu_ready !== 1'b0) begin
          errors++;
          $display("FAIL refill_ready addr=%h beat=%0d: cpu_ready=%b required 0", a, bt, cpu_ready);
        end
        @(negedge clk);
        cyc++;
        n++;
      end
      mem_rvalid = 1'b0;
      flush      = 1'b0;
      mem_rdata  = $urandom;
      #1;
      for (int k = 0; k < 4; k++) m_data[s][v][k] = mem[{blk[15:4], k[1:0]}];
      m_tag[s][v]   = t;
      m_valid[s][v] = 1'b1;
      m_touch(s, v);
      exp = m_data[s][v][wd];
      checks++;
      if (cpu_ready !== 1'b1 || cpu_rdata !== exp) begin
        errors++;
        $display("FAIL respond addr=%h: ready=%b rdata=%h required ready=1 rdata=%h", a, cpu_ready, cpu_rdata, exp);
      end
      if (exp_lat > 0) begin
        checks++;
        if (cyc != exp_lat) begin
          errors++;
          $display("FAIL miss_latency addr=%h: %0d cycles required %0d", a, cyc, exp_lat);
        end
      end
      @(negedge clk);
      cpu_req = 1'b0;
    end
  endtask

  // Watches the FLUSH sweep: busy high for exactly 4 cycles with no cpu_ready, then idle.
  task automatic check_flush_window(input string nm);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || cpu_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: busy=%b ready=%b required busy=1 ready=0", nm, i, busy, cpu_ready);
      end
      @(negedge clk);
    end
    cpu_req = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end: busy=%b required 0", nm, busy);
    end
    m_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_addr = 16'h0104; flush = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    m_clear();
    @(negedge clk);
    #1;
    checks++;
    if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b rdata=%h mem_req=%b mem_addr=%h busy=%b required all zero",
               cpu_ready, cpu_rdata, mem_req, mem_addr, busy);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_miss_latency();
    mem[14'h040] = 32'hA0; mem[14'h041] = 32'hA1;
    mem[14'h042] = 32'hA2; mem[14'h043] = 32'hA3;
    do_access(16'h0104, 0, 0, 0, 16'h0, 0, -1, 6);
    do_access(16'h010C, 1, 0, 0, 16'h0, 0, -1, 0);
  endtask

  task automatic test_plru();
    do_access(16'h0500, 0, 0, 0, 16'h0, 0, -1, 0);
    do_access(16'h0100, 1, 0, 0, 16'h0, 0, -1, 0);
    do_access(16'h0900, 0, 0, 0, 16'h0, 0, -1, 0);
    do_access(16'h0100, 1, 0, 0, 16'h0, 0, -1, 0);
    do_access(16'h0500, 0, 0, 0, 16'h0, 0, -1, 0);
    do_access(16'h0908, 0, 0, 0, 16'h0, 0, -1, 0);
  endtask

  task automatic test_rvalid_gaps();
    do_access(16'h0A24, 0, 0, 1, 16'h0059, 7, -1, 0);
    do_access(16'h0A2C, 1, 0, 0, 16'h0, 0, -1, 0);
  endtask

  task automatic test_flush_hit();
    do_access(16'h0310, 0, 0, 0, 16'h0, 0, -1, 0);
    cpu_req = 1'b1; cpu_addr = 16'h0314; flush = 1'b1;
    #1;
    checks++;
    if (cpu_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_prio: ready=%b busy=%b required 0 0", cpu_ready, busy);
    end
    @(negedge clk);
    flush = 1'b0;
    check_flush_window("flush_hit");
    @(negedge clk);
    do_access(16'h0314, 0, 0, 0, 16'h0, 0, -1, 0);
  endtask

  task automatic test_flush_in_refill();
    do_access(16'h0C28, 0, 0, 0, 16'h0, 0, 1, 0);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_pend_idle: busy=%b required 0", busy);
    end
    @(negedge clk);
    check_flush_window("flush_refill");
    @(negedge clk);
    do_access(16'h0C28, 0, 20, 0, 16'h0, 0, -1, 0);
  endtask

  task automatic test_reset_mid_refill();
    do_access(16'h0730, 0, 0, 0, 16'h0, 0, -1, 0);
    cpu_req = 1'b1; cpu_addr = 16'h0B34;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      @(negedge clk);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_refill: mem_req=%b busy=%b ready=%b required 0 0 0", mem_req, busy, cpu_ready);
    end
    m_clear();
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    do_access(16'h0730, 0, 0, 0, 16'h0, 0, -1, 0);
    do_access(16'h0B34, 0, 0, 0, 16'h0, 0, -1, 6);
    do_access(16'h0B3C, 1, 0, 0, 16'h0, 0, -1, 0);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 80; i++) begin
      a = 16'($urandom);
      a[15:6] = 10'($urandom_range(0, 5));
      do_access(a, -1, 25, $urandom_range(0, 2), 16'h0, 0, -1, 0);
      if (i % 25 == 24) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_flush_window("flush_idle");
        @(negedge clk);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    test_reset();
    test_miss_latency();
    test_plru();
    test_rvalid_gaps();
    test_flush_hit();
    test_flush_in_refill();
    test_reset_mid_refill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
